// File: rtl/instruction_encoder.sv
// Packs instruction fields (R/RI/I/J formats) into words and writes them to consecutive
// instruction-memory addresses. Optional macro ENCODER_FIELD_CHECK_EN rejects out-of-range immediates.
module instruction_encoder #(
  parameter int INSTRUCTION_SIZE = 20,
  parameter int OP_SIZE          = 6,
  parameter int REG_ADDRESS_SIZE = 2,
  parameter int IMEM_ADDR_SIZE   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [IMEM_ADDR_SIZE-1:0]   base_addr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  fmt,
  input  logic [OP_SIZE-1:0]          opcode,
  input  logic [REG_ADDRESS_SIZE-1:0] rAlpha,
  input  logic [REG_ADDRESS_SIZE-1:0] rBeta,
  input  logic [REG_ADDRESS_SIZE-1:0] rGamma,
  input  logic [15:0]                 imm,
  input  logic                        in_last,
  output logic                        imem_we,
  output logic [IMEM_ADDR_SIZE-1:0]   imem_addr,
  output logic [INSTRUCTION_SIZE-1:0] imem_wdata,
  output logic                        busy,
  output logic                        full,
  output logic                        done,
  output logic                        err
);

  localparam int OP_LSB    = INSTRUCTION_SIZE - OP_SIZE;
  localparam int ALPHA_LSB = OP_LSB - REG_ADDRESS_SIZE;
  localparam int BETA_LSB  = ALPHA_LSB - REG_ADDRESS_SIZE;
  localparam int GAMMA_LSB = BETA_LSB - REG_ADDRESS_SIZE;
  localparam int RI_IMM_W  = BETA_LSB;
  localparam int I_IMM_W   = ALPHA_LSB;
  localparam int J_LSB     = 5;
  localparam int J_IMM_W   = OP_LSB - J_LSB;

  typedef enum logic [1:0] {IDLE, ACTIVE, FULL} stateType;
  typedef enum logic [1:0] {FMT_R, FMT_RI, FMT_I, FMT_J} fmtType;

  stateType                    state, stateNext;
  logic [IMEM_ADDR_SIZE-1:0]   wrPtr, wrPtrNext;
  logic [IMEM_ADDR_SIZE-1:0]   addrNext;
  logic [INSTRUCTION_SIZE-1:0] encoded, wdataNext;
  logic                        weNext, doneNext, errNext, immOk;

  assign busy     = (state == ACTIVE);
  assign in_ready = (state == ACTIVE);
  assign full     = (state == FULL);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    encoded = '0;
    encoded[INSTRUCTION_SIZE-1 -: OP_SIZE] = opcode;
    case (fmtType'(fmt))
      FMT_R: begin
        encoded[ALPHA_LSB +: REG_ADDRESS_SIZE] = rAlpha;
        encoded[BETA_LSB  +: REG_ADDRESS_SIZE] = rBeta;
        encoded[GAMMA_LSB +: REG_ADDRESS_SIZE] = rGamma;
      end
      FMT_RI: begin
        encoded[ALPHA_LSB +: REG_ADDRESS_SIZE] = rAlpha;
        encoded[BETA_LSB  +: REG_ADDRESS_SIZE] = rBeta;
        encoded[RI_IMM_W-1:0]                  = imm[RI_IMM_W-1:0];
      end
      FMT_I: begin
        encoded[ALPHA_LSB +: REG_ADDRESS_SIZE] = rAlpha;
        encoded[I_IMM_W-1:0]                   = imm[I_IMM_W-1:0];
      end
      default: encoded[J_LSB +: J_IMM_W] = imm[J_IMM_W-1:0];
    endcase
  end

`ifdef ENCODER_FIELD_CHECK_EN
  localparam int RI_MAX = 2**(RI_IMM_W-1) - 1;
  localparam int I_MAX  = 2**(I_IMM_W-1) - 1;
  localparam int J_MAX  = 2**J_IMM_W - 1;

  logic signed [31:0] immValue;
  assign immValue = 32'($signed(imm));

  always_comb begin
    immOk = 1'b1;
    case (fmtType'(fmt))
      FMT_RI:  immOk = (immValue >= -(RI_MAX + 1)) && (immValue <= RI_MAX);
      FMT_I:   immOk = (immValue >= -(I_MAX + 1)) && (immValue <= I_MAX);
      FMT_J:   immOk = (immValue >= 0) && (immValue <= J_MAX);
      default: immOk = 1'b1;
    endcase
  end
`else
  // Immediates are silently truncated; the upper bits and error path are never consumed.
  logic unusedBits;
  assign immOk      = 1'b1;
  assign unusedBits = ^{imm[15:I_IMM_W], errNext};
  assign err        = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    wrPtrNext = wrPtr;
    weNext    = 1'b0;
    addrNext  = imem_addr;
    wdataNext = imem_wdata;
    doneNext  = 1'b0;
    errNext   = 1'b0;
    case (state)
      ACTIVE: begin
        if (in_valid) begin
          if (immOk) begin
            weNext    = 1'b1;
            addrNext  = wrPtr;
            wdataNext = encoded;
            wrPtrNext = wrPtr + IMEM_ADDR_SIZE'(1);
          end else begin
            errNext = 1'b1;
          end
          // A last word ends the load even if it lands on the top address.
          if (in_last)
            stateNext = IDLE;
          else if (immOk && (wrPtr == '1))
            stateNext = FULL;
          doneNext = in_last;
        end
      end
      default: begin
        if (start) begin
          wrPtrNext = base_addr;
          stateNext = ACTIVE;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the write port registers are reset too, so a pending write vanishes the moment reset asserts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wrPtr      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
    end else begin
      state      <= stateNext;
      wrPtr      <= wrPtrNext;
      imem_we    <= weNext;
      imem_addr  <= addrNext;
      imem_wdata <= wdataNext;
      done       <= doneNext;
    end
  end

`ifdef ENCODER_FIELD_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= errNext;
  end
`endif

endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: encoding vector table, directed corner sequences,
// and randomized traffic against an integer-arithmetic model of the loader.
module tb_instruction_encoder;

`ifdef ENCODER_FIELD_CHECK_EN
  localparam bit FIELD_CHECK = 1'b1;
`else
  localparam bit FIELD_CHECK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_ready, in_last;
  logic [7:0]  base_addr, imem_addr;
  logic [1:0]  fmt, rAlpha, rBeta, rGamma;
  logic [5:0]  opcode;
  logic [15:0] imm;
  logic        imem_we, busy, full, done, err;
  logic [19:0] imem_wdata;

  instruction_encoder dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode),
    .rAlpha(rAlpha), .rBeta(rBeta), .rGamma(rGamma), .imm(imm), .in_last(in_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .full(full), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Loader model: plain integers for pointer and encoding.
  bit mActive, mFull;
  int mPtr;
  bit expWe, expDone, expErr;
  int expAddr, expWdata;

  function automatic int wrapMod(int v, int m);
    return ((v % m) + m) % m;
  endfunction

  function automatic int refEncode(int f, int op, int a, int b, int g, int immV);
    case (f)
      0:       return op * 16384 + a * 4096 + b * 1024 + g * 256;
      1:       return op * 16384 + a * 4096 + b * 1024 + wrapMod(immV, 1024);
      2:       return op * 16384 + a * 4096 + wrapMod(immV, 4096);
      default: return op * 16384 + wrapMod(immV, 512) * 32;
    endcase
  endfunction

  function automatic bit immLegal(int f, int immV);
    case (f)
      1:       return immV >= -512 && immV <= 511;
      2:       return immV >= -2048 && immV <= 2047;
      3:       return immV >= 0 && immV <= 511;
      default: return 1'b1;
    endcase
  endfunction

  task automatic modelReset();
    mActive = 0; mFull = 0; mPtr = 0;
    expWe = 0; expDone = 0; expErr = 0; expAddr = 0; expWdata = 0;
  endtask

  task automatic resetOutputsCheck(input string tag);
    check({tag, " in_ready"}, in_ready, 0);
    check({tag, " imem_we"}, imem_we, 0);
    check({tag, " imem_addr"}, imem_addr, 0);
    check({tag, " imem_wdata"}, imem_wdata, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " full"}, full, 0);
    check({tag, " done"}, done, 0);
    check({tag, " err"}, err, 0);
  endtask

  // Called at a falling edge: drive inputs, advance the model, clock once, compare at the next falling edge.
  task automatic step(input bit st, input int base, input bit valid, input int f, input int op,
                      input int a, input int b, input int g, input int immV, input bit last);
    bit legal, wroteTop;
    start = st; base_addr = base[7:0]; in_valid = valid; fmt = f[1:0]; opcode = op[5:0];
    rAlpha = a[1:0]; rBeta = b[1:0]; rGamma = g[1:0]; imm = immV[15:0]; in_last = last;

    expWe = 0; expDone = 0; expErr = 0; wroteTop = 0;
    if (!mActive) begin
      if (st) begin mPtr = base % 256; mActive = 1; mFull = 0; end
    end else if (valid) begin
      legal = FIELD_CHECK ? immLegal(f, immV) : 1'b1;
      if (legal) begin
        expWe = 1; expAddr = mPtr; expWdata = refEncode(f, op, a, b, g, immV);
        wroteTop = (mPtr == 255);
        mPtr = (mPtr + 1) % 256;
      end else begin
        expErr = 1;
      end
      if (last) begin expDone = 1; mActive = 0; end
      else if (wroteTop) begin mActive = 0; mFull = 1; end
    end

    @(posedge clk);
    @(negedge clk);
    start = 0; in_valid = 0;
    check("busy", busy, mActive);
    check("in_ready", in_ready, mActive);
    check("full", full, mFull);
    check("imem_we", imem_we, expWe);
    check("done", done, expDone);
    check("err", err, expErr);
    if (expWe) begin
      check("imem_addr", imem_addr, expAddr);
      check("imem_wdata", imem_wdata, expWdata);
    end
  endtask

  task automatic startLoad(input int base);
    step(1, base, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idleCycle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    int f, op, a, b, g, immV;
    int expWdata;
  } vecType;

  vecType vecs[8];

  initial begin
    vecs[0] = '{f: 0, op: 'h01, a: 1, b: 2, g: 3, immV: 0,     expWdata: 'h05B00};
    vecs[1] = '{f: 1, op: 'h02, a: 3, b: 0, g: 0, immV: -1,    expWdata: 'h0B3FF};
    vecs[2] = '{f: 2, op: 'h03, a: 2, b: 0, g: 0, immV: 'h7FF, expWdata: 'h0E7FF};
    vecs[3] = '{f: 3, op: 'h04, a: 3, b: 3, g: 3, immV: 'h1FF, expWdata: 'h13FE0};
    vecs[4] = '{f: 0, op: 'h3F, a: 3, b: 3, g: 3, immV: -1,    expWdata: 'hFFF00};
    vecs[5] = '{f: 2, op: 'h00, a: 0, b: 0, g: 0, immV: -2048, expWdata: 'h00800};
    vecs[6] = '{f: 3, op: 'h3F, a: 0, b: 0, g: 0, immV: 0,     expWdata: 'hFC000};
    vecs[7] = '{f: 1, op: 'h15, a: 1, b: 1, g: 0, immV: -512,  expWdata: 'h55600};

    reset = 1; start = 0; base_addr = 0; in_valid = 0; fmt = 0; opcode = 0;
    rAlpha = 0; rBeta = 0; rGamma = 0; imm = 0; in_last = 0;
    modelReset();
    #2;
    resetOutputsCheck("por");
    @(posedge clk);
    @(negedge clk);
    reset = 0;

    // Each vector is a single-word program at 0x10.
    for (int i = 0; i < 8; i++) begin
      startLoad('h10);
      step(0, 0, 1, vecs[i].f, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].g, vecs[i].immV, 1);
      check($sformatf("vec%0d wdata", i), imem_wdata, vecs[i].expWdata);
      check($sformatf("vec%0d addr", i), imem_addr, 'h10);
      check($sformatf("vec%0d done", i), done, 1);
    end

    // Back-to-back two-word program.
    startLoad('h10);
    step(0, 0, 1, 1, 'h02, 3, 0, 0, -1, 0);
    check("b2b first wdata", imem_wdata, 'h0B3FF);
    check("b2b first addr", imem_addr, 'h10);
    check("b2b first done", done, 0);
    step(0, 0, 1, 2, 'h03, 2, 0, 0, 'h7FF, 1);
    check("b2b second wdata", imem_wdata, 'h0E7FF);
    check("b2b second addr", imem_addr, 'h11);
    check("b2b second done", done, 1);
    idleCycle();
    check("b2b idle busy", busy, 0);
    check("b2b idle we", imem_we, 0);

    // Out-of-range RI immediate.
    startLoad('h40);
    step(0, 0, 1, 1, 'h02, 0, 0, 0, 600, 1);
    if (FIELD_CHECK) begin
      check("imm600 err", err, 1);
      check("imm600 we", imem_we, 0);
    end else begin
      check("imm600 wdata", imem_wdata, 'h08258);
      check("imm600 err", err, 0);
    end
    check("imm600 done", done, 1);

    // Fill to the top of memory.
    startLoad('hFE);
    step(0, 0, 1, 0, 'h01, 1, 1, 1, 0, 0);
    check("fill addr FE", imem_addr, 'hFE);
    step(0, 0, 1, 0, 'h02, 2, 2, 2, 0, 0);
    check("fill addr FF", imem_addr, 'hFF);
    check("fill full", full, 1);
    check("fill in_ready", in_ready, 0);
    step(0, 0, 1, 0, 'h03, 3, 3, 3, 0, 0);
    check("fill third not written", imem_we, 0);
    check("fill full sticky", full, 1);
    startLoad('h20);
    check("restart clears full", full, 0);
    check("restart busy", busy, 1);
    step(0, 0, 1, 0, 'h05, 0, 1, 2, 0, 1);
    check("restart addr", imem_addr, 'h20);

    // Reset lands while an accepted word is being written.
    startLoad('h30);
    in_valid = 1; fmt = 0; opcode = 6'h01; rAlpha = 1; rBeta = 2; rGamma = 3; in_last = 0;
    @(posedge clk);
    #2;
    check("pre-reset we", imem_we, 1);
    reset = 1;
    #1;
    resetOutputsCheck("async");
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    modelReset();
    step(0, 0, 1, 0, 'h01, 1, 2, 3, 0, 0);
    check("post-reset no write", imem_we, 0);
    step(0, 0, 1, 2, 'h07, 1, 0, 0, 5, 1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      bit st, valid, last;
      int base, f, immV;
      st    = ($urandom % 8) == 0;
      base  = ($urandom % 2 == 0) ? int'(8'hF8 + 8'($urandom % 8)) : int'($urandom % 256);
      valid = ($urandom % 4) != 0;
      last  = ($urandom % 12) == 0;
      f     = int'($urandom % 4);
      case ($urandom % 3)
        0:       immV = int'($urandom_range(0, 1300)) - 650;
        1:       immV = int'($urandom % 65536) - 32768;
        default: immV = int'($urandom_range(0, 4500)) - 2250;
      endcase
      step(st, base, valid, f, int'($urandom % 64), int'($urandom % 4), int'($urandom % 4),
           int'($urandom % 4), immV, last);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
